// File: rtl/period_sweep_controller_pkg.sv
// Shared constants for the period sweep controller: default widths, idle period
// and the FSM state encoding.
package period_sweep_controller_pkg;

    localparam int         WIDTH_DEFAULT      = 8;
    localparam logic [7:0] DEFAULT_PERIOD_VAL = 8'd50;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_REG_RST = 3'd2;
    localparam logic [2:0] ST_DWELL   = 3'd3;
    localparam logic [2:0] ST_STEP    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/period_sweep_controller_edge_counter.sv
// Counts rising edges of the divided clock and flags the edge that reaches the target.
// The history flop runs continuously so an edge is never invented when counting resumes.
module period_sweep_controller_edge_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             clear,
    input  logic [WIDTH-1:0] target,
    output logic             hit
);

    logic             sig_q;
    logic [WIDTH-1:0] count_q;
    logic             rise;

    assign rise = sig & ~sig_q;
    assign hit  = rise & ~clear & (({1'b0, count_q} + 1'b1) >= {1'b0, target});

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q   <= 1'b0;
            count_q <= '0;
        end else begin
            sig_q <= sig;
            if (clear) begin
                count_q <= '0;
            end else if (rise) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/period_sweep_controller.sv
// Steps the regulator period from start to end, resetting the regulator around each
// change and dwelling a programmed number of divided-clock edges at each value.
module period_sweep_controller
    import period_sweep_controller_pkg::*;
#(
    parameter int               WIDTH          = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(DEFAULT_PERIOD_VAL),
    parameter int               REG_RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] startPeriod,
    input  logic [WIDTH-1:0] endPeriod,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] dwell,
    input  logic             clk_div,
    output logic [WIDTH-1:0] setPeriod,
    output logic             regRst,
    output logic             busy,
    output logic             done
);

    localparam int RC_W = $clog2(REG_RST_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REG_RST_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] start_q, end_q, step_q, dwell_q;
    logic             up_q;
    logic [WIDTH-1:0] period_q, period_d;
    logic [RC_W-1:0]  rr_cnt_q;
    logic [WIDTH:0]   next_ext;
    logic             passed;
    logic             dwell_hit;
    logic             regrst_q, busy_q, done_q;

    period_sweep_controller_edge_counter #(.WIDTH(WIDTH)) u_edge_counter (
        .clk    (clk),
        .rst_n  (rst),
        .sig    (clk_div),
        .clear  (state_q != ST_DWELL),
        .target (dwell_q),
        .hit    (dwell_hit)
    );

    // The extra top bit is the carry on the way up and the borrow on the way down.
    assign next_ext = up_q ? ({1'b0, period_q} + {1'b0, step_q})
                           : ({1'b0, period_q} - {1'b0, step_q});
    assign passed   = next_ext[WIDTH] |
                      (up_q ? (next_ext[WIDTH-1:0] > end_q) : (next_ext[WIDTH-1:0] < end_q));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                period_d = start_q;
                state_d  = ST_REG_RST;
            end
            ST_REG_RST: if (rr_cnt_q == RC_LAST) state_d = ST_DWELL;
            ST_DWELL:   if (dwell_hit) state_d = ST_STEP;
            ST_STEP: begin
                if ((period_q == end_q) || passed) begin
                    state_d = ST_DONE;
                end else begin
                    period_d = next_ext[WIDTH-1:0];
                    state_d  = ST_REG_RST;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            period_d = period_q;
        end
    end

    // NOTE: every register, captured configuration included, has an explicit reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            period_q <= DEFAULT_PERIOD;
            start_q  <= '0;
            end_q    <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            up_q     <= 1'b0;
            rr_cnt_q <= '0;
            regrst_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            if ((state_q == ST_IDLE) && start) begin
                start_q <= startPeriod;
                end_q   <= endPeriod;
                step_q  <= (step == '0)  ? WIDTH'(1) : step;
                dwell_q <= (dwell == '0) ? WIDTH'(1) : dwell;
                up_q    <= (startPeriod <= endPeriod);
            end
            rr_cnt_q <= ((state_q == ST_REG_RST) && (state_d == ST_REG_RST))
                        ? rr_cnt_q + 1'b1 : '0;
            // Outputs are registered from the next state so the regulator sees no decode glitches.
            regrst_q <= (state_d == ST_REG_RST);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign setPeriod = period_q;
    assign regRst    = regrst_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
